// File: rtl/fan_timer_if.sv
// Button-pulse inputs and timer status outputs of the fan off-timer.
// The block is the slave; the button front-end and fan FSM side is the master.
interface fan_timer_if #(
    parameter int N_PRESETS = 3,
    parameter int CNT_W     = 8
);
    localparam int PRW = $clog2(N_PRESETS + 1);

    logic             i_button_U;
    logic             i_button_C;
    logic             i_button_D;
    logic [2:0]       o_timerState;
    logic [PRW-1:0]   o_preset;
    logic [CNT_W-1:0] o_remaining;
    logic             o_done_pulse;
    logic             o_fan_en;

    modport slave (
        input  i_button_U, i_button_C, i_button_D,
        output o_timerState, o_preset, o_remaining, o_done_pulse, o_fan_en
    );

    modport master (
        output i_button_U, i_button_C, i_button_D,
        input  o_timerState, o_preset, o_remaining, o_done_pulse, o_fan_en
    );
endinterface

// File: rtl/fan_timer_ctrl.sv
// Fan off-timer: preset selection, 1 s prescaled countdown with pause/resume,
// and a DONE state that gates the fan until acknowledged.
module fan_timer_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int N_PRESETS = 3,
    parameter int STEP_SEC  = 5,
    parameter int CNT_W     = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    fan_timer_if.slave  bus
);
    localparam int PRW = $clog2(N_PRESETS + 1);
    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_PAUSE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]       state_q,  state_d;
    logic [PRW-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [PW-1:0]    presc_q,  presc_d;
    logic             done_q,   done_d;
    logic             tick_s;

    assign tick_s = (presc_q == PW'(TICK_DIV - 1));

    // State and counter registers with immediate asynchronous reset
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            preset_q <= PRW'(0);
            remain_q <= CNT_W'(0);
            presc_q  <= PW'(0);
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            remain_q <= remain_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; button priority inside each state is D > C > U
    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        remain_d = remain_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_button_U) begin
                    state_d  = ST_SELECT;
                    preset_d = PRW'(1);
                    remain_d = CNT_W'(STEP_SEC);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (bus.i_button_D) begin
                    state_d  = ST_IDLE;
                    preset_d = PRW'(0);
                    remain_d = CNT_W'(0);
                end else if (bus.i_button_C) begin
                    state_d = ST_RUN;
                    presc_d = PW'(0);
                end else if (bus.i_button_U) begin
                    if (preset_q == PRW'(N_PRESETS)) begin
                        state_d  = ST_IDLE;
                        preset_d = PRW'(0);
                        remain_d = CNT_W'(0);
                    end else begin
                        preset_d = preset_q + PRW'(1);
                        remain_d = CNT_W'((32'(preset_q) + 32'd1) * 32'(STEP_SEC));
                    end
                end else begin
                    state_d = ST_SELECT;
                end
            end
            ST_RUN: begin
                // Cancel beats expiry, expiry beats pause
                if (bus.i_button_D) begin
                    state_d  = ST_IDLE;
                    preset_d = PRW'(0);
                    remain_d = CNT_W'(0);
                    presc_d  = PW'(0);
                end else if (tick_s && (remain_q <= CNT_W'(1))) begin
                    state_d  = ST_DONE;
                    remain_d = CNT_W'(0);
                    presc_d  = PW'(0);
                    done_d   = 1'b1;
                end else if (bus.i_button_C) begin
                    state_d = ST_PAUSE;
                end else if (tick_s) begin
                    presc_d  = PW'(0);
                    remain_d = remain_q - CNT_W'(1);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_PAUSE: begin
                if (bus.i_button_D) begin
                    state_d  = ST_IDLE;
                    preset_d = PRW'(0);
                    remain_d = CNT_W'(0);
                    presc_d  = PW'(0);
                end else if (bus.i_button_C) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (bus.i_button_D) begin
                    state_d  = ST_IDLE;
                    preset_d = PRW'(0);
                    remain_d = CNT_W'(0);
                    presc_d  = PW'(0);
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                preset_d = PRW'(0);
                remain_d = CNT_W'(0);
                presc_d  = PW'(0);
            end
        endcase
    end

    // Outputs come straight from registers; only the fan enable is decoded
    always_comb begin
        bus.o_timerState = state_q;
        bus.o_preset     = preset_q;
        bus.o_remaining  = remain_q;
        bus.o_done_pulse = done_q;
        bus.o_fan_en     = (state_q != ST_DONE);
    end
endmodule

// File: tb/tb_fan_timer_ctrl.sv
// Directed bench for fan_timer_ctrl with TICK_DIV=4, STEP_SEC=5, N_PRESETS=3.
module tb_fan_timer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fan_timer_if #(.N_PRESETS(3), .CNT_W(8)) bus ();

    fan_timer_ctrl #(.TICK_DIV(4), .N_PRESETS(3), .STEP_SEC(5), .CNT_W(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic u, input logic c, input logic d);
        bus.i_button_U = u;
        bus.i_button_C = c;
        bus.i_button_D = d;
        @(posedge clk);
        #1;
        bus.i_button_U = 1'b0;
        bus.i_button_C = 1'b0;
        bus.i_button_D = 1'b0;
    endtask

    task automatic chk_st(input string tag, input int st, input int pr, input int rem);
        chk({tag, "_state"}, 32'(bus.o_timerState), st);
        chk({tag, "_preset"}, 32'(bus.o_preset), pr);
        chk({tag, "_remain"}, 32'(bus.o_remaining), rem);
    endtask

    initial begin
        bus.i_button_U = 1'b0;
        bus.i_button_C = 1'b0;
        bus.i_button_D = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk_st("reset", 0, 0, 0);
        chk("reset_fan", 32'(bus.o_fan_en), 1);
        chk("reset_done", 32'(bus.o_done_pulse), 0);
        step(2);
        rst = 1'b0;
        step(1);

        // IDLE ignores C and D
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk_st("idle_ign", 0, 0, 0);

        // Preset stepping and wrap
        press(1'b1, 1'b0, 1'b0);
        chk_st("sel1", 1, 1, 5);
        press(1'b1, 1'b0, 1'b0);
        chk_st("sel2", 1, 2, 10);
        press(1'b1, 1'b0, 1'b0);
        chk_st("sel3", 1, 3, 15);
        press(1'b1, 1'b0, 1'b0);
        chk_st("wrap", 0, 0, 0);

        // Full countdown of preset 1
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk_st("run_start", 2, 1, 5);
        for (int k = 1; k <= 4; k++) begin
            step(3);
            chk("pre_tick", 32'(bus.o_remaining), 32'(6 - k));
            step(1);
            chk("post_tick", 32'(bus.o_remaining), 32'(5 - k));
        end
        step(3);
        chk_st("before_done", 2, 1, 1);
        chk("before_done_fan", 32'(bus.o_fan_en), 1);
        step(1);
        chk_st("done", 4, 1, 0);
        chk("done_pulse", 32'(bus.o_done_pulse), 1);
        chk("done_fan", 32'(bus.o_fan_en), 0);
        step(1);
        chk("done_pulse_end", 32'(bus.o_done_pulse), 0);
        press(1'b1, 1'b1, 1'b0);
        chk_st("done_ign", 4, 1, 0);
        press(1'b0, 1'b0, 1'b1);
        chk_st("ack", 0, 0, 0);
        chk("ack_fan", 32'(bus.o_fan_en), 1);

        // Pause two cycles after a tick, hold, resume
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        step(4);
        chk("p_tick", 32'(bus.o_remaining), 9);
        step(2);
        press(1'b0, 1'b1, 1'b0);
        chk_st("paused", 3, 2, 9);
        step(50);
        chk_st("frozen", 3, 2, 9);
        press(1'b0, 1'b1, 1'b0);
        chk_st("resumed", 2, 2, 9);
        step(1);
        chk("resume_1", 32'(bus.o_remaining), 9);
        step(1);
        chk("resume_2", 32'(bus.o_remaining), 8);
        press(1'b0, 1'b0, 1'b1);
        chk_st("cancel", 0, 0, 0);

        // Final tick coincident with C: expiry wins
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        step(19);
        chk_st("last_sec", 2, 1, 1);
        press(1'b0, 1'b1, 1'b0);
        chk_st("tick_c", 4, 1, 0);
        chk("tick_c_pulse", 32'(bus.o_done_pulse), 1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b1);
        chk_st("sel_du", 0, 0, 0);

        // D coincident with a tick at remaining 3
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        step(28);
        chk_st("rem3", 2, 2, 3);
        step(3);
        press(1'b0, 1'b0, 1'b1);
        chk_st("tick_d", 0, 0, 0);
        chk("tick_d_pulse", 32'(bus.o_done_pulse), 0);
        step(1);
        chk("tick_d_pulse2", 32'(bus.o_done_pulse), 0);

        // Asynchronous reset mid-RUN at remaining 7
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        step(12);
        chk_st("rem7", 2, 2, 7);
        rst = 1'b1;
        #1;
        chk_st("async_rst", 0, 0, 0);
        chk("async_rst_fan", 32'(bus.o_fan_en), 1);
        step(1);
        rst = 1'b0;
        step(1);
        chk_st("post_rst", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
